branch_predict_unit: RTL and testbench

//  Parametrised branch target buffer (BTB) with 2-bit saturating direction counters for the pipelined MIPS core.

---
 rtl/branch_predict_unit.sv | 120 ++++++++++++
 tb/tb_branch_predict_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch target buffer with 2-bit saturating direction counters, mispredict detection,
// a sequential invalidate sweep and a mispredict statistics counter.
module branch_predict_unit #(
  parameter int         ADDR_W    = 32,
  parameter int         DEPTH     = 64,
  parameter int         TAG_W     = 8,
  parameter logic [1:0] ALLOC_CTR = 2'b10,
  parameter int         CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  input  logic              inv_req,
  output logic              busy,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int INDEX_W = $clog2(DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [DEPTH-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem    [DEPTH];
  logic [ADDR_W-1:0]  target_mem [DEPTH];
  logic [1:0]         ctr_mem    [DEPTH];
  state_t             state;
  logic [INDEX_W-1:0] ptr;

  logic [INDEX_W-1:0] if_idx, upd_idx;
  logic [TAG_W-1:0]   if_tag, upd_tag;
  logic               upd_hit, train_en;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  assign if_idx  = if_pc[INDEX_W+1:2];
  assign if_tag  = if_pc[INDEX_W+TAG_W+1:INDEX_W+2];
  assign upd_idx = upd_pc[INDEX_W+1:2];
  assign upd_tag = upd_pc[INDEX_W+TAG_W+1:INDEX_W+2];

  assign busy     = (state == CLEAR);
  assign upd_hit  = valid[upd_idx] && (tag_mem[upd_idx] == upd_tag);
  assign train_en = upd_valid && !busy;

  // Lookup reads the arrays before this edge's write, giving read-before-write for free.
  // NOTE: every output of always_comb gets a default first so no path can infer a latch.
  always_comb begin
    pred_hit    = 1'b0;
    pred_taken  = 1'b0;
    pred_target = if_pc + ADDR_W'(4);
    if (valid[if_idx] && (tag_mem[if_idx] == if_tag) && !busy) begin
      pred_hit   = 1'b1;
      pred_taken = ctr_mem[if_idx][1];
      if (pred_taken) pred_target = target_mem[if_idx];
    end
  end

  assign mispredict  = upd_valid && ((upd_pred_taken != upd_taken) ||
                                     (upd_taken && (upd_pred_target != upd_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + ADDR_W'(4);

  // Valid bits and the sweep FSM share one block: only valid needs reset to empty the BTB.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (train_en && !upd_hit && upd_taken) valid[upd_idx] <= 1'b1;
          if (inv_req) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        CLEAR: begin
          valid[ptr] <= 1'b0;
          ptr        <= ptr + 1'b1;
          if (ptr == INDEX_W'(DEPTH - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag/target/counter arrays are deliberately not reset; valid alone gates their use.
  always_ff @(posedge clk) begin
    if (train_en) begin
      if (upd_hit) begin
        ctr_mem[upd_idx] <= ctr_next(ctr_mem[upd_idx], upd_taken);
        if (upd_taken) target_mem[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        tag_mem[upd_idx]    <= upd_tag;
        target_mem[upd_idx] <= upd_target;
        ctr_mem[upd_idx]    <= ALLOC_CTR;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           miss_count <= '0;
    else if (mispredict) miss_count <= miss_count + 1'b1;
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (DEPTH=64, TAG_W=8).
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic        upd_taken, upd_pred_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        inv_req;
  logic        busy;
  logic [15:0] miss_count;

  int checks   = 0;
  int failures = 0;
  int exp_miss = 0;
  int n_busy;

  branch_predict_unit dut (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .inv_req(inv_req), .busy(busy), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
    #1;
  endtask

  task automatic upd_tick(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
    set_upd(pc, tk, tgt, ptk, ptgt);
    tick();
    upd_valid = 1'b0;
    #1;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic hit,
                        input logic tk, input logic [31:0] tgt);
    if_pc = pc;
    #1;
    check({tag, "_hit"}, {31'b0, pred_hit}, {31'b0, hit});
    check({tag, "_taken"}, {31'b0, pred_taken}, {31'b0, tk});
    check({tag, "_target"}, pred_target, tgt);
  endtask

  initial begin
    reset = 1'b1; if_pc = 32'h0040_0010; inv_req = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_pred_taken = 1'b0; upd_pred_target = '0;
    tick(); tick();
    reset = 1'b0;
    #1;

    // T1: reset state
    lookup("t1", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
    check("t1_busy", {31'b0, busy}, 32'd0);
    check("t1_miss", {16'b0, miss_count}, 32'd0);
    check("t1_mispredict", {31'b0, mispredict}, 32'd0);

    // T2 + T6-style read-before-write: allocate 0x40, lookup same cycle still misses
    if_pc = 32'h40;
    set_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    check("t2_mispredict", {31'b0, mispredict}, 32'd1);
    check("t2_redirect", redirect_pc, 32'h100);
    check("t2_same_cycle_hit", {31'b0, pred_hit}, 32'd0);
    tick(); upd_valid = 1'b0; exp_miss++;
    check("t2_miss", {16'b0, miss_count}, exp_miss);
    lookup("t2", 32'h40, 1'b1, 1'b1, 32'h100);

    // T3: 10 -> 01 (not-taken mispredict, redirect to pc+4)
    set_upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    check("t3_mispredict_nt", {31'b0, mispredict}, 32'd1);
    check("t3_redirect_nt", redirect_pc, 32'h44);
    tick(); upd_valid = 1'b0; exp_miss++;
    lookup("t3_ctr01", 32'h40, 1'b1, 1'b0, 32'h44);
    // 01 -> 00 -> 00 (saturate low), correctly predicted
    set_upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    check("t3_no_mispredict", {31'b0, mispredict}, 32'd0);
    tick(); upd_valid = 1'b0;
    upd_tick(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    // 00 -> 01: still not taken if it did not underflow to 11
    upd_tick(32'h40, 1'b1, 32'h100, 1'b0, 32'h0); exp_miss++;
    lookup("t3_sat_low", 32'h40, 1'b1, 1'b0, 32'h44);
    // 01 -> 10 -> 11 -> 11 -> 11, then not-taken -> 10 keeps predicting taken
    for (int i = 0; i < 4; i++) upd_tick(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    upd_tick(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    lookup("t3_sat_high", 32'h40, 1'b1, 1'b1, 32'h100);
    // Wrong predicted target on a taken branch
    set_upd(32'h40, 1'b1, 32'h180, 1'b1, 32'h100);
    check("t3_mispredict_tgt", {31'b0, mispredict}, 32'd1);
    check("t3_redirect_tgt", redirect_pc, 32'h180);
    tick(); upd_valid = 1'b0; exp_miss++;
    lookup("t3_new_target", 32'h40, 1'b1, 1'b1, 32'h180);
    check("t3_miss", {16'b0, miss_count}, exp_miss);

    // T4: aliasing on index 16 (tags 0, 1, 2)
    lookup("t4_alias_miss", 32'h140, 1'b0, 1'b0, 32'h144);
    upd_tick(32'h140, 1'b1, 32'h300, 1'b0, 32'h0); exp_miss++;
    lookup("t4_replaced", 32'h140, 1'b1, 1'b1, 32'h300);
    lookup("t4_old_gone", 32'h40, 1'b0, 1'b0, 32'h44);
    upd_tick(32'h240, 1'b0, 32'h0, 1'b0, 32'h0);
    lookup("t4_nt_no_alloc", 32'h240, 1'b0, 1'b0, 32'h244);
    lookup("t4_kept", 32'h140, 1'b1, 1'b1, 32'h300);

    // T6: same-cycle allocate and lookup of 0x80
    if_pc = 32'h80;
    set_upd(32'h80, 1'b1, 32'h500, 1'b1, 32'h500);
    check("t6_same_cycle_hit", {31'b0, pred_hit}, 32'd0);
    tick(); upd_valid = 1'b0;
    lookup("t6_next", 32'h80, 1'b1, 1'b1, 32'h500);

    // T5: invalidate sweep
    inv_req = 1'b1; tick(); inv_req = 1'b0;
    n_busy = 0;
    check("t5_busy_start", {31'b0, busy}, 32'd1);
    lookup("t5_masked", 32'h80, 1'b0, 1'b0, 32'h84);
    n_busy++; tick();
    // Update to index 0 after the sweep has passed it: must be dropped
    set_upd(32'h100, 1'b1, 32'h600, 1'b0, 32'h0);
    check("t5_mispredict_busy", {31'b0, mispredict}, 32'd1);
    check("t5_redirect_busy", redirect_pc, 32'h600);
    n_busy++; tick(); upd_valid = 1'b0; exp_miss++;
    check("t5_miss_busy", {16'b0, miss_count}, exp_miss);
    inv_req = 1'b1; n_busy++; tick(); inv_req = 1'b0;
    while (busy && n_busy < 200) begin
      n_busy++;
      tick();
    end
    check("t5_busy_cycles", n_busy, 32'd64);
    check("t5_busy_end", {31'b0, busy}, 32'd0);
    lookup("t5_dropped", 32'h100, 1'b0, 1'b0, 32'h104);
    lookup("t5_cleared_80", 32'h80, 1'b0, 1'b0, 32'h84);
    lookup("t5_cleared_140", 32'h140, 1'b0, 1'b0, 32'h144);

    // T5b: reset mid-sweep
    upd_tick(32'h80, 1'b1, 32'h500, 1'b1, 32'h500);
    lookup("t5b_refill", 32'h80, 1'b1, 1'b1, 32'h500);
    inv_req = 1'b1; tick(); inv_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("t5b_busy_mid", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("t5b_busy_reset", {31'b0, busy}, 32'd0);
    check("t5b_miss_reset", {16'b0, miss_count}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t5b_busy_after", {31'b0, busy}, 32'd0);
    lookup("t5b_after", 32'h80, 1'b0, 1'b0, 32'h84);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
